// File: rtl/sobel_stream.sv
// sobel_stream: streaming 3x3 Sobel edge detector with line buffers and valid/ready handshake.
module sobel_stream #(
  parameter int PIX_W = 8,
  parameter int OUT_W = 8,
  parameter int IMG_W = 640,
  parameter int SHIFT = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(IMG_W+1)-1:0]   line_width,
  input  logic [1:0]                   mode,
  input  logic [OUT_W-1:0]             threshold,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PIX_W-1:0]             in_pix,
  input  logic                         sof_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_W-1:0]             out_pix,
  output logic                         out_sof,
  output logic                         out_border
);
  localparam int CW = $clog2(IMG_W + 1);
  localparam int GW = PIX_W + 4;
  localparam logic [CW-1:0] WMAX = CW'(IMG_W);
  localparam logic [CW-1:0] WMIN = CW'(3);
  localparam logic [GW-1:0] OMAX = GW'((1 << OUT_W) - 1);
  logic en, acc, wrap;
  logic [CW-1:0] eff, col, c, eff_n;
  logic [15:0] row, r;
  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] a_pix, a_top, a_mid;
  logic [PIX_W-1:0] w [9];
  logic [GW-1:0] e [9];
  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0] ax, ay, sel, mag;
  logic a_v, a_s, a_b, w_v, w_s, w_b, g_v, g_s, g_b;
  logic [1:0] a_m, w_m, g_m;
  logic [OUT_W-1:0] a_t, w_t, g_t;
  assign en = out_ready | ~out_valid;
  assign in_ready = en;
  assign acc = in_valid & en;
  // sof forces this pixel to (0,0) and reloads the active width
  assign c = sof_in ? '0 : col;
  assign r = sof_in ? '0 : row;
  assign eff_n = !sof_in ? eff : line_width < WMIN ? WMIN : line_width > WMAX ? WMAX : line_width;
  assign wrap = c == eff_n - 1'b1;
  always_comb begin
    for (int i = 0; i < 9; i++) e[i] = GW'(w[i]);
    ax = gx[GW-1] ? -gx : gx;
    ay = gy[GW-1] ? -gy : gy;
    sel = g_m == 2'd2 ? ax : g_m == 2'd3 ? ay : ax + ay;
    mag = sel >> SHIFT;
  end
  // datapath storage: line buffers read-before-write at the same column
  always_ff @(posedge clk) begin
    if (acc) begin
      a_pix <= in_pix;
      a_top <= lb1[c];
      a_mid <= lb0[c];
      lb1[c] <= lb0[c];
      lb0[c] <= in_pix;
    end
    if (en && a_v) begin
      w[0] <= w[1]; w[1] <= w[2]; w[2] <= a_top;
      w[3] <= w[4]; w[4] <= w[5]; w[5] <= a_mid;
      w[6] <= w[7]; w[7] <= w[8]; w[8] <= a_pix;
    end
    if (en) begin
      gx <= (e[2] + (e[5] << 1) + e[8]) - (e[0] + (e[3] << 1) + e[6]);
      gy <= (e[0] + (e[1] << 1) + e[2]) - (e[6] + (e[7] << 1) + e[8]);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eff <= WMAX;
      col <= '0;
      row <= '0;
      {a_v, a_s, a_b, w_v, w_s, w_b, g_v, g_s, g_b} <= '0;
      {a_m, w_m, g_m} <= '0;
      {a_t, w_t, g_t} <= '0;
      out_valid <= 1'b0;
      out_pix <= '0;
      out_sof <= 1'b0;
      out_border <= 1'b0;
    end else if (en) begin
      a_v <= acc;
      w_v <= a_v;
      g_v <= w_v;
      out_valid <= g_v;
      if (acc) begin
        a_s <= sof_in;
        a_b <= r < 16'd2 || c < CW'(2);
        a_m <= mode;
        a_t <= threshold;
        eff <= eff_n;
        col <= wrap ? '0 : c + 1'b1;
        row <= wrap ? (&r ? r : r + 1'b1) : r;
      end
      {w_s, w_b, w_m, w_t} <= {a_s, a_b, a_m, a_t};
      {g_s, g_b, g_m, g_t} <= {w_s, w_b, w_m, w_t};
      out_sof <= g_s;
      out_border <= g_b;
      out_pix <= g_b ? '0 : g_m == 2'd1 ? {OUT_W{mag >= GW'(g_t)}} : mag > OMAX ? '1 : mag[OUT_W-1:0];
    end
  end
endmodule
